load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word memory operation at a time, issues a
// single held memory request, and returns an extended load result or an error status.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [1:0]  out_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Memory operation encodings shared with the decoder.
    localparam logic [5:0] ALU_LB  = 6'd32;
    localparam logic [5:0] ALU_LH  = 6'd33;
    localparam logic [5:0] ALU_LW  = 6'd34;
    localparam logic [5:0] ALU_LBU = 6'd35;
    localparam logic [5:0] ALU_LHU = 6'd36;
    localparam logic [5:0] ALU_SB  = 6'd40;
    localparam logic [5:0] ALU_SH  = 6'd41;
    localparam logic [5:0] ALU_SW  = 6'd42;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t             state;
    logic [5:0]         op_code;
    logic [1:0]         op_offset;
    logic [CNT_W-1:0]   cnt;

    logic               in_is_mem;
    logic               in_is_store;
    size_t              in_size;
    logic               in_misaligned;
    logic [3:0]         in_be;
    logic [31:0]        in_wdata;
    logic [31:0]        rdata_shifted;
    logic [31:0]        load_data;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        in_is_mem   = 1'b0;
        in_is_store = 1'b0;
        in_size     = SZ_BYTE;
        case (alucode)
            ALU_LB, ALU_LBU: begin in_is_mem = 1'b1; in_size = SZ_BYTE; end
            ALU_LH, ALU_LHU: begin in_is_mem = 1'b1; in_size = SZ_HALF; end
            ALU_LW:          begin in_is_mem = 1'b1; in_size = SZ_WORD; end
            ALU_SB: begin in_is_mem = 1'b1; in_is_store = 1'b1; in_size = SZ_BYTE; end
            ALU_SH: begin in_is_mem = 1'b1; in_is_store = 1'b1; in_size = SZ_HALF; end
            ALU_SW: begin in_is_mem = 1'b1; in_is_store = 1'b1; in_size = SZ_WORD; end
            default: ;
        endcase
    end

    always_comb begin
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = store_data;
        case (in_size)
            SZ_BYTE: begin
                in_be    = 4'b0001 << addr[1:0];
                in_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                in_misaligned = addr[0];
                in_be         = addr[1] ? 4'b1100 : 4'b0011;
                in_wdata      = {2{store_data[15:0]}};
            end
            default: begin
                in_misaligned = (addr[1:0] != 2'b00);
                in_be         = 4'b1111;
                in_wdata      = store_data;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend by operation type.
    assign rdata_shifted = mem_rdata >> {op_offset, 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (op_code)
            ALU_LB:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            ALU_LBU: load_data = {24'h0, rdata_shifted[7:0]};
            ALU_LH:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            ALU_LHU: load_data = {16'h0, rdata_shifted[15:0]};
            ALU_LW:  load_data = mem_rdata;
            default: load_data = 32'h0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values and the order of statements inside the block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_code   <= 6'h0;
            op_offset <= 2'b00;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_err   <= 1'b0;
            out_cause <= CAUSE_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_is_mem) begin
                        op_code   <= alucode;
                        op_offset <= addr[1:0];
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        if (in_misaligned) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= 32'h0;
                            out_err   <= 1'b1;
                            out_cause <= CAUSE_MISALIGN;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= in_is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= in_be;
                            mem_wdata <= in_wdata;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= load_data;
                        out_err   <= 1'b0;
                        out_cause <= CAUSE_NONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= 32'h0;
                        out_err   <= 1'b1;
                        out_cause <= CAUSE_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte/half/word loads and stores, misalignment,
// timeout, ack-vs-timeout precedence, reset mid-request and back-to-back acceptance.
module tb_load_store_unit;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_LB  = 6'd32;
    localparam logic [5:0] ALU_LH  = 6'd33;
    localparam logic [5:0] ALU_LW  = 6'd34;
    localparam logic [5:0] ALU_LBU = 6'd35;
    localparam logic [5:0] ALU_LHU = 6'd36;
    localparam logic [5:0] ALU_SB  = 6'd40;
    localparam logic [5:0] ALU_SH  = 6'd41;
    localparam logic [5:0] ALU_SW  = 6'd42;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic [1:0]  out_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucode    (alucode),
        .addr       (addr),
        .store_data (store_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_cause  (out_cause),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one operation for a single cycle, then scrambles the inputs so any
    // later dependence on them shows up. Returns at the negedge after acceptance.
    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd);
        in_valid = 1'b1; alucode = code; addr = a; store_data = sd;
        step();
        in_valid = 1'b0; alucode = ALU_SW; addr = 32'hFFFF_FFFF; store_data = 32'h5555_5555;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; alucode = ALU_ADD; addr = 32'h0; store_data = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({out_valid, out_err, out_cause, mem_req, mem_we, mem_be} !== 10'h0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {out_valid, out_err, out_cause, mem_req, mem_we, mem_be}); end
        checks++; if ({out_data, mem_addr, mem_wdata} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {out_data, mem_addr, mem_wdata}); end
    endtask

    task automatic test_lw_wait();
        issue(ALU_LW, 32'h0000_0100, 32'h0);
        checks++; if ({mem_req, mem_we, mem_be, in_ready} !== 7'b1_0_1111_0) begin
            failures++; $display("FAIL lw_req got=%b exp=1011110", {mem_req, mem_we, mem_be, in_ready}); end
        checks++; if (mem_addr !== 32'h0000_0100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", mem_addr); end
        step();
        checks++; if ({mem_req, out_valid} !== 2'b10) begin failures++; $display("FAIL lw_wait got=%b exp=10", {mem_req, out_valid}); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        checks++; if ({out_valid, out_err, out_cause, mem_req} !== 5'b1_0_00_0) begin
            failures++; $display("FAIL lw_done got=%b exp=10000", {out_valid, out_err, out_cause, mem_req}); end
        checks++; if (out_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", out_data); end
        step();
        checks++; if ({out_valid, in_ready} !== 2'b01 || out_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lw_hold got=%b/%h exp=01/deadbeef", {out_valid, in_ready}, out_data); end
    endtask

    // Zero-wait loads: ack in the first request cycle, result two cycles after acceptance.
    task automatic test_load_extend();
        logic [5:0]  codes [4] = '{ALU_LB,       ALU_LBU,      ALU_LH,       ALU_LHU};
        logic [31:0] addrs [4] = '{32'h103,      32'h103,      32'h302,      32'h300};
        logic [31:0] rdat  [4] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_7777, 32'h1234_F00D};
        logic [3:0]  bes   [4] = '{4'b1000,      4'b1000,      4'b1100,      4'b0011};
        logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D};
        for (int i = 0; i < 4; i++) begin
            issue(codes[i], addrs[i], 32'h0);
            checks++; if ({mem_req, mem_we, mem_be} !== {2'b10, bes[i]}) begin
                failures++; $display("FAIL ld%0d_be got=%b exp=10%b", i, {mem_req, mem_we, mem_be}, bes[i]); end
            checks++; if (mem_addr !== {addrs[i][31:2], 2'b00}) begin
                failures++; $display("FAIL ld%0d_addr got=%h exp=%h", i, mem_addr, {addrs[i][31:2], 2'b00}); end
            mem_ack = 1'b1; mem_rdata = rdat[i];
            step();
            mem_ack = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== exps[i]) begin
                failures++; $display("FAIL ld%0d_data got=%b/%h exp=1/%h", i, out_valid, out_data, exps[i]); end
            step();
        end
    endtask

    task automatic test_store();
        logic [5:0]  codes [3] = '{ALU_SH,       ALU_SB,       ALU_SW};
        logic [31:0] addrs [3] = '{32'h202,      32'h101,      32'h40C};
        logic [31:0] sds   [3] = '{32'h1234_ABCD, 32'h0000_00EF, 32'hCAFE_F00D};
        logic [3:0]  bes   [3] = '{4'b1100,      4'b0010,      4'b1111};
        logic [31:0] wds   [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hCAFE_F00D};
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], addrs[i], sds[i]);
            checks++; if ({mem_req, mem_we, mem_be} !== {2'b11, bes[i]}) begin
                failures++; $display("FAIL st%0d_be got=%b exp=11%b", i, {mem_req, mem_we, mem_be}, bes[i]); end
            checks++; if (mem_wdata !== wds[i] || mem_addr !== {addrs[i][31:2], 2'b00}) begin
                failures++; $display("FAIL st%0d_wdata got=%h@%h exp=%h@%h", i, mem_wdata, mem_addr, wds[i], {addrs[i][31:2], 2'b00}); end
            mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
            step();
            mem_ack = 1'b0;
            checks++; if ({out_valid, out_err} !== 2'b10 || out_data !== 32'h0) begin
                failures++; $display("FAIL st%0d_done got=%b/%h exp=10/00000000", i, {out_valid, out_err}, out_data); end
            step();
        end
    endtask

    task automatic test_misaligned();
        logic [5:0]  codes [3] = '{ALU_LW,  ALU_LHU, ALU_SW};
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h206};
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], addrs[i], 32'h1111_1111);
            checks++; if ({out_valid, out_err, out_cause, mem_req} !== 5'b1_1_01_0) begin
                failures++; $display("FAIL mis%0d got=%b exp=11010", i, {out_valid, out_err, out_cause, mem_req}); end
            step();
            checks++; if ({out_valid, mem_req, in_ready} !== 3'b001) begin
                failures++; $display("FAIL mis%0d_after got=%b exp=001", i, {out_valid, mem_req, in_ready}); end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(ALU_LW, 32'h0000_0200, 32'h0);
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=8", n); end
        checks++; if ({out_valid, out_err, out_cause} !== 4'b1_1_10 || out_data !== 32'h0) begin
            failures++; $display("FAIL timeout_done got=%b/%h exp=1110/00000000", {out_valid, out_err, out_cause}, out_data); end
        step();
    endtask

    task automatic test_ack_vs_timeout();
        issue(ALU_LW, 32'h0000_0204, 32'h0);
        repeat (7) step();
        checks++; if ({mem_req, out_valid} !== 2'b10) begin failures++; $display("FAIL race_last_cycle got=%b exp=10", {mem_req, out_valid}); end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        checks++; if ({out_valid, out_err, out_cause} !== 4'b1_0_00 || out_data !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL race_ack_wins got=%b/%h exp=1000/0badf00d", {out_valid, out_err, out_cause}, out_data); end
        step();
    endtask

    task automatic test_non_mem();
        in_valid = 1'b1; alucode = ALU_ADD; addr = 32'h0000_0100;
        step(); step();
        in_valid = 1'b0;
        checks++; if ({in_ready, mem_req, out_valid} !== 3'b100) begin
            failures++; $display("FAIL non_mem got=%b exp=100", {in_ready, mem_req, out_valid}); end
    endtask

    task automatic test_reset_during_req();
        int seen = 0;
        issue(ALU_LW, 32'h0000_0300, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({mem_req, in_ready, out_valid} !== 3'b010 || out_data !== 32'h0) begin
            failures++; $display("FAIL rst_req got=%b/%h exp=010/00000000", {mem_req, in_ready, out_valid}, out_data); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid === 1'b1 || mem_req === 1'b1) seen++;
        end
        mem_ack = 1'b0;
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_stray_ack got=%0d exp=0", seen); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    endtask

    // in_valid held high: the second acceptance must wait for the cycle after out_valid.
    task automatic test_back_to_back();
        in_valid = 1'b1; alucode = ALU_LW; addr = 32'h0000_0101;
        step();
        checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL b2b_first got=%b exp=10", {out_valid, in_ready}); end
        step();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL b2b_gap got=%b exp=01", {out_valid, in_ready}); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_cause} !== 3'b1_01) begin failures++; $display("FAIL b2b_second got=%b exp=101", {out_valid, out_cause}); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_load_extend();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_vs_timeout();
        test_non_mem();
        test_reset_during_req();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
